// File: rtl/uart_pkg.sv
// Shared types and constants for the memory-mapped UART blocks.
package uart_pkg;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

  localparam logic [1:0] UART_DATA_OFS = 2'b00;
  localparam logic [1:0] UART_STAT_OFS = 2'b10;

  localparam int ST_BUSY  = 0;
  localparam int ST_EMPTY = 1;
  localparam int ST_FULL  = 2;
  localparam int ST_OVF   = 3;

endpackage

// File: rtl/uart_tx_io_if.sv
// CPU I/O bus slice seen by the UART: chip select, strobes, offset and data.
interface uart_tx_io_if;
  logic        uartcs;
  logic        uartwrite;
  logic        uartread;
  logic [1:0]  uartaddr;
  logic [7:0]  uartwdata;
  logic [15:0] uartrdata;

  modport master (output uartcs, uartwrite, uartread, uartaddr, uartwdata,
                  input  uartrdata);
  modport slave  (input  uartcs, uartwrite, uartread, uartaddr, uartwdata,
                  output uartrdata);
endinterface

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO; push at full and pop at empty are ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr, r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push, w_do_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop  & ~o_empty;
  assign o_dout    = r_mem[r_rptr];

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr] <= i_din;
  end

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_io.sv
// Memory-mapped 8N1 UART transmitter: DATA pushes into a FIFO, STATUS polls
// {overflow, full, empty, busy}; the FSM drains the FIFO onto a registered tx.
module uart_tx_io
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ  = 23_000_000,
  parameter int BAUD         = 115_200,
  parameter int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  uart_tx_io_if.slave  bus,
  output logic         tx
);
  localparam int             BW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0]  BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  tx_state_t     r_state;
  logic [BW-1:0] r_baud;
  logic [2:0]    r_idx;
  logic [7:0]    r_shift;
  logic          r_tx;
  logic          r_ovf;

  logic          w_push, w_stat_rd, w_pop;
  logic          w_full, w_empty, w_busy, w_baud_end;
  logic [7:0]    w_head;
  logic [15:0]   w_status;

  assign w_push     = bus.uartcs & bus.uartwrite & (bus.uartaddr == UART_DATA_OFS);
  assign w_stat_rd  = bus.uartcs & bus.uartread  & (bus.uartaddr == UART_STAT_OFS);
  assign w_baud_end = (r_baud == BAUD_LAST);
  assign w_busy     = (r_state != TX_IDLE);
  // Pops line up exactly with the FSM transitions that load the shifter.
  assign w_pop      = ~w_empty & ((r_state == TX_IDLE) |
                                  ((r_state == TX_STOP) & w_baud_end));

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   (bus.uartwdata),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_comb begin
    w_status           = '0;
    w_status[ST_BUSY]  = w_busy;
    w_status[ST_EMPTY] = w_empty;
    w_status[ST_FULL]  = w_full;
    w_status[ST_OVF]   = r_ovf;
  end

  assign bus.uartrdata = w_stat_rd ? w_status : 16'h0000;
  assign tx            = r_tx;

  // A drop on the same edge as a status read keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 r_ovf <= 1'b0;
    else if (w_push & w_full)   r_ovf <= 1'b1;
    else if (w_stat_rd)         r_ovf <= 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= TX_IDLE;
      r_baud  <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
    end else begin
      case (r_state)
        TX_IDLE: begin
          r_tx <= 1'b1;
          if (!w_empty) begin
            r_shift <= w_head;
            r_baud  <= '0;
            r_state <= TX_START;
            r_tx    <= 1'b0;
          end
        end
        TX_START: begin
          if (w_baud_end) begin
            r_baud  <= '0;
            r_idx   <= '0;
            r_state <= TX_DATA;
            r_tx    <= r_shift[0];
          end else begin
            r_baud  <= r_baud + 1'b1;
          end
        end
        TX_DATA: begin
          if (w_baud_end) begin
            r_baud <= '0;
            if (r_idx == 3'd7) begin
              r_state <= TX_STOP;
              r_tx    <= 1'b1;
            end else begin
              r_idx   <= r_idx + 1'b1;
              r_shift <= {1'b0, r_shift[7:1]};
              r_tx    <= r_shift[1];
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        TX_STOP: begin
          if (w_baud_end) begin
            r_baud <= '0;
            if (!w_empty) begin
              r_shift <= w_head;
              r_state <= TX_START;
              r_tx    <= 1'b0;
            end else begin
              r_state <= TX_IDLE;
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        default: begin
          r_state <= TX_IDLE;
          r_tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_io.sv
// Directed bench for uart_tx_io at CLKS_PER_BIT=4, FIFO_DEPTH=16.
module tb_uart_tx_io;
  import uart_pkg::*;

  localparam int CPB   = 4;
  localparam int DEPTH = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic tx;

  uart_tx_io_if bus();

  uart_tx_io #(
    .CLK_FREQ_HZ  (460_800),
    .BAUD         (115_200),
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .tx    (tx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        cs;
    logic        wr;
    logic        rd;
    logic [1:0]  addr;
    logic [7:0]  wdata;
    logic [15:0] exp_rd;
    logic [15:0] exp_st;
  } vec_t;

  vec_t       vt [10];
  int         total = 0;
  int         bad   = 0;
  logic [7:0] pend_q [$];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic bus_idle();
    bus.uartcs    = 1'b0;
    bus.uartwrite = 1'b0;
    bus.uartread  = 1'b0;
    bus.uartaddr  = 2'b00;
    bus.uartwdata = 8'h00;
  endtask

  task automatic drive_wr(input logic [7:0] d);
    bus.uartcs    = 1'b1;
    bus.uartwrite = 1'b1;
    bus.uartread  = 1'b0;
    bus.uartaddr  = UART_DATA_OFS;
    bus.uartwdata = d;
  endtask

  // Combinational status look with no clock edge, so overflow is untouched.
  task automatic peek_stat(input string name, input logic [15:0] exp);
    bus.uartcs    = 1'b1;
    bus.uartwrite = 1'b0;
    bus.uartread  = 1'b1;
    bus.uartaddr  = UART_STAT_OFS;
    #1;
    chk(name, bus.uartrdata, exp);
    bus_idle();
  endtask

  // Samples tx after each of the 10*CPB edges starting with the start-bit edge.
  task automatic frame_check(input logic [7:0] b, input string nm);
    logic e;
    int   k;
    for (int j = 0; j < 10*CPB; j++) begin
      @(posedge clk); #1;
      if (pend_q.size() > 0) drive_wr(pend_q.pop_front());
      else                   bus_idle();
      k = j / CPB;
      if (k == 0)      e = 1'b0;
      else if (k == 9) e = 1'b1;
      else             e = b[k-1];
      chk($sformatf("%s tx cyc%0d", nm, j), {15'b0, tx}, {15'b0, e});
    end
  endtask

  initial begin
    vt[0] = '{1'b1, 1'b0, 1'b1, 2'b10, 8'h00, 16'h0002, 16'h0002};
    vt[1] = '{1'b1, 1'b0, 1'b1, 2'b00, 8'h00, 16'h0000, 16'h0002};
    vt[2] = '{1'b0, 1'b0, 1'b1, 2'b10, 8'h00, 16'h0000, 16'h0002};
    vt[3] = '{1'b1, 1'b0, 1'b1, 2'b01, 8'h00, 16'h0000, 16'h0002};
    vt[4] = '{1'b1, 1'b1, 1'b0, 2'b10, 8'h3C, 16'h0000, 16'h0002};
    vt[5] = '{1'b0, 1'b1, 1'b0, 2'b00, 8'h3C, 16'h0000, 16'h0002};
    vt[6] = '{1'b1, 1'b1, 1'b0, 2'b01, 8'h3C, 16'h0000, 16'h0002};
    vt[7] = '{1'b1, 1'b1, 1'b0, 2'b11, 8'h3C, 16'h0000, 16'h0002};
    vt[8] = '{1'b1, 1'b0, 1'b1, 2'b11, 8'h00, 16'h0000, 16'h0002};
    vt[9] = '{1'b1, 1'b1, 1'b0, 2'b00, 8'hA5, 16'h0000, 16'h0000};

    bus_idle();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset tx", {15'b0, tx}, 16'h0001);
    chk("reset rdata idle", bus.uartrdata, 16'h0000);
    peek_stat("reset status", 16'h0002);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Decode table; the last row queues 0xA5 and leaves it pending.
    for (int i = 0; i < 10; i++) begin
      bus.uartcs    = vt[i].cs;
      bus.uartwrite = vt[i].wr;
      bus.uartread  = vt[i].rd;
      bus.uartaddr  = vt[i].addr;
      bus.uartwdata = vt[i].wdata;
      #1;
      chk($sformatf("vec%0d rdata", i), bus.uartrdata, vt[i].exp_rd);
      @(posedge clk); #1;
      bus_idle();
      peek_stat($sformatf("vec%0d status", i), vt[i].exp_st);
    end

    frame_check(8'hA5, "single");
    peek_stat("single last stop", 16'h0003);
    @(posedge clk); #1;
    peek_stat("single done", 16'h0002);
    chk("single idle tx", {15'b0, tx}, 16'h0001);

    repeat (3) @(posedge clk);
    #1;
    drive_wr(8'h00);
    @(posedge clk); #1;
    drive_wr(8'hFF);
    pend_q.push_back(8'h55);
    frame_check(8'h00, "burst0");
    peek_stat("burst after f0", 16'h0001);
    frame_check(8'hFF, "burst1");
    peek_stat("burst after f1", 16'h0001);
    frame_check(8'h55, "burst2");
    peek_stat("burst after f2", 16'h0003);
    @(posedge clk); #1;
    peek_stat("burst done", 16'h0002);

    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 18; k++) begin
      drive_wr(8'h10 + 8'(k));
      @(posedge clk); #1;
    end
    bus_idle();
    peek_stat("ovf status", 16'h000D);
    bus.uartcs   = 1'b1;
    bus.uartread = 1'b1;
    bus.uartaddr = UART_STAT_OFS;
    #1;
    chk("ovf read data", bus.uartrdata, 16'h000D);
    @(posedge clk); #1;
    bus_idle();
    peek_stat("ovf cleared", 16'h0005);

    // Frame 1 started on the second write edge; its STOP pops 40 edges later.
    repeat (22) @(posedge clk);
    #1;
    chk("stall stop bit", {15'b0, tx}, 16'h0001);
    drive_wr(8'hEE);
    @(posedge clk); #1;
    bus_idle();
    chk("full+pop next start", {15'b0, tx}, 16'h0000);
    peek_stat("full+pop drop", 16'h0009);
    drive_wr(8'hEF);
    @(posedge clk); #1;
    bus_idle();
    peek_stat("refill to full", 16'h000D);

    #2;
    rst_n = 1'b0;
    #1;
    chk("async reset tx", {15'b0, tx}, 16'h0001);
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    peek_stat("post-reset status", 16'h0002);
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      chk($sformatf("post-reset tx%0d", c), {15'b0, tx}, 16'h0001);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
